// File: rtl/mp_ram_pkg.sv
// rtl/mp_ram_pkg.sv - shared types, legal parameter values and helpers for mp_ram
package mp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int RD_LAT_MIN  = 1;
    localparam int RD_LAT_MAX  = 2;
    localparam int WF_OLD_DATA = 0;
    localparam int WF_NEW_DATA = 1;
    localparam int NPORTS_MAX  = 8;

    // Number of byte lanes in a word of data_w bits.
    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mp_ram_wmerge.sv
// rtl/mp_ram_wmerge.sv - per-byte-lane write priority merge across all ports
module mp_ram_wmerge
    import mp_ram_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic [NPORTS-1:0]                wr_i,
    input  logic [NPORTS-1:0][DATA_W/8-1:0]  be_i,
    input  logic [NPORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NPORTS-1:0][DATA_W-1:0]    wdata_i,
    output logic [NPORTS-1:0][DATA_W-1:0]    merged_o,
    output logic [NPORTS-1:0][DATA_W/8-1:0]  mask_o,
    output logic [NPORTS-1:0]                coll_o
);

    localparam int LANES = lane_count(DATA_W);

    // merged_o/mask_o describe the post-write word at port r's address; scanning
    // q upward lets the highest-index writer own each lane.
    always_comb begin
        merged_o = '0;
        mask_o   = '0;
        coll_o   = '0;
        for (int r = 0; r < NPORTS; r++) begin
            for (int l = 0; l < LANES; l++) begin
                for (int q = 0; q < NPORTS; q++) begin
                    if (wr_i[q] && be_i[q][l] && (addr_i[q] == addr_i[r])) begin
                        merged_o[r][l*8 +: 8] = wdata_i[q][l*8 +: 8];
                        mask_o[r][l]          = 1'b1;
                        if ((q > r) && wr_i[r] && be_i[r][l]) begin
                            coll_o[r] = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mp_ram.sv
// rtl/mp_ram.sv - parametrised multi-port RAM with lane merge, clear sweep and read pipeline
module mp_ram
    import mp_ram_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                NPORTS      = 2,
    parameter int                RD_LATENCY  = 1,
    parameter int                WRITE_FIRST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL    = '0,
    localparam int               ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int               LANES       = lane_count(DATA_W)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             init_i,
    output logic                             busy_o,
    input  logic [NPORTS-1:0]                req_i,
    input  logic [NPORTS-1:0]                we_i,
    input  logic [NPORTS-1:0][LANES-1:0]     be_i,
    input  logic [NPORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NPORTS-1:0][DATA_W-1:0]    wdata_i,
    output logic [NPORTS-1:0]                rvalid_o,
    output logic [NPORTS-1:0][DATA_W-1:0]    rdata_o,
    output logic [NPORTS-1:0]                coll_o
);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("mp_ram: DATA_W must be a multiple of 8");
    end
    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_chk_rd_lat
        $error("mp_ram: RD_LATENCY must be 1 or 2");
    end
    if (NPORTS < 1 || NPORTS > NPORTS_MAX) begin : g_chk_nports
        $error("mp_ram: NPORTS must be in 1..8");
    end
    if (WRITE_FIRST != WF_OLD_DATA && WRITE_FIRST != WF_NEW_DATA) begin : g_chk_wf
        $error("mp_ram: WRITE_FIRST must be 0 or 1");
    end

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               ptr_q, ptr_d;
    logic [NPORTS-1:0]               rv1_q, rv1_d, rv2_q, rv2_d;
    logic [NPORTS-1:0][DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
    logic [NPORTS-1:0]               coll_q, coll_d;

    logic                            busy;
    logic [NPORTS-1:0]               wr_vec, rd_vec, in_range;
    logic [NPORTS-1:0][DATA_W-1:0]   merged, rd_word;
    logic [NPORTS-1:0][LANES-1:0]    mask;
    logic [NPORTS-1:0]               wcoll;

    assign busy   = (state_q == ST_CLEAR);
    assign busy_o = busy;
    assign wr_vec = busy ? '0 : (req_i & we_i);
    assign rd_vec = busy ? '0 : (req_i & ~we_i);

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            in_range[p] = (int'(addr_i[p]) < DEPTH);
        end
    end

    mp_ram_wmerge #(
        .NPORTS (NPORTS),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wmerge (
        .wr_i     (wr_vec),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .merged_o (merged),
        .mask_o   (mask),
        .coll_o   (wcoll)
    );

    // Out-of-range reads return zero even when a same-cycle write targets them.
    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (in_range[p]) begin
                rd_word[p] = mem[addr_i[p]];
                if (WRITE_FIRST == WF_NEW_DATA) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (mask[p][l]) begin
                            rd_word[p][l*8 +: 8] = merged[p][l*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rv1_d   = rv1_q;
        rd1_d   = rd1_q;
        rv2_d   = rv2_q;
        rd2_d   = rd2_q;
        coll_d  = coll_q;
        if (en) begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                default: begin
                    if (init_i) begin
                        state_d = ST_CLEAR;
                        ptr_d   = '0;
                    end
                end
            endcase
            rv1_d = rd_vec;
            for (int p = 0; p < NPORTS; p++) begin
                if (rd_vec[p]) begin
                    rd1_d[p] = rd_word[p];
                end
            end
            rv2_d  = rv1_q;
            rd2_d  = rd1_q;
            coll_d = wcoll;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            rv1_q   <= '0;
            rd1_q   <= '0;
            rv2_q   <= '0;
            rd2_q   <= '0;
            coll_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rv1_q   <= rv1_d;
            rd1_q   <= rd1_d;
            rv2_q   <= rv2_d;
            rd2_q   <= rd2_d;
            coll_q  <= coll_d;
        end
    end

    // The array has no reset; the clear sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (busy) begin
                mem[ptr_q] <= INIT_VAL;
            end else begin
                for (int p = 0; p < NPORTS; p++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (mask[p][l] && in_range[p]) begin
                            mem[addr_i[p]][l*8 +: 8] <= merged[p][l*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign rvalid_o = (RD_LATENCY == RD_LAT_MAX) ? rv2_q : rv1_q;
    assign rdata_o  = (RD_LATENCY == RD_LAT_MAX) ? rd2_q : rd1_q;
    assign coll_o   = coll_q;

endmodule

// File: tb/tb_mp_ram.sv
// tb/tb_mp_ram.sv - self-checking bench for mp_ram against a behavioural memory model
module tb_mp_ram;

    localparam int NP  = 2;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst_n, en, init_i;
    logic [NP-1:0]             req_i, we_i;
    logic [NP-1:0][3:0]        be_i;
    logic [NP-1:0][AW-1:0]     addr_i;
    logic [NP-1:0][DW-1:0]     wdata_i;

    logic                      busy_a, busy_b, busy_c;
    logic [NP-1:0]             rvalid_a, rvalid_b, rvalid_c, coll_a, coll_b, coll_c;
    logic [NP-1:0][DW-1:0]     rdata_a, rdata_b, rdata_c;

    int total = 0;
    int bad   = 0;

    // Behavioural model: plain word array plus the spec's sweep/priority rules.
    logic [DW-1:0]         mem_m [DEP];
    bit                    m_clear;
    int                    m_ptr;
    logic [NP-1:0]         exp_v1, exp_v2, exp_coll, hv;
    logic [NP-1:0][DW-1:0] exp_d1, exp_d2, hd;

    always #5 clk = ~clk;

    mp_ram #(.DATA_W(DW), .DEPTH(DEP), .NPORTS(NP), .RD_LATENCY(1), .WRITE_FIRST(1), .INIT_VAL(INIT)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .init_i(init_i), .busy_o(busy_a),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .coll_o(coll_a));

    mp_ram #(.DATA_W(DW), .DEPTH(DEP), .NPORTS(NP), .RD_LATENCY(2), .WRITE_FIRST(0), .INIT_VAL(INIT)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .init_i(init_i), .busy_o(busy_b),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .coll_o(coll_b));

    mp_ram #(.DATA_W(DW), .DEPTH(12), .NPORTS(NP), .RD_LATENCY(1), .WRITE_FIRST(1), .INIT_VAL(INIT)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .init_i(init_i), .busy_o(busy_c),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_c), .rdata_o(rdata_c), .coll_o(coll_c));

    task automatic idle();
        req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic set_port(input int p, input logic rq, input logic w, input logic [3:0] b,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[p] = rq; we_i[p] = w; be_i[p] = b; addr_i[p] = a; wdata_i[p] = d;
    endtask

    task automatic model_reset();
        m_clear = 1'b1; m_ptr = 0;
        exp_v1 = '0; exp_v2 = '0; exp_coll = '0; hv = '0;
        exp_d1 = '0; exp_d2 = '0; hd = '0;
    endtask

    // Advance the model for the current inputs, then let the DUTs take the edge.
    task automatic tick();
        logic [NP-1:0][DW-1:0] oldw, neww;
        logic [NP-1:0]         rv, cl;
        oldw = '0; neww = '0; rv = '0; cl = '0;
        if (en && rst_n) begin
            if (m_clear) begin
                mem_m[m_ptr] = INIT;
                m_ptr++;
                if (m_ptr == DEP) m_clear = 1'b0;
            end else begin
                for (int p = 0; p < NP; p++) oldw[p] = mem_m[addr_i[p]];
                for (int p = 0; p < NP; p++)
                    for (int l = 0; l < 4; l++)
                        if (req_i[p] && we_i[p] && be_i[p][l])
                            for (int q = p + 1; q < NP; q++)
                                if (req_i[q] && we_i[q] && be_i[q][l] && addr_i[q] == addr_i[p]) cl[p] = 1'b1;
                for (int p = 0; p < NP; p++)
                    for (int l = 0; l < 4; l++)
                        if (req_i[p] && we_i[p] && be_i[p][l])
                            mem_m[addr_i[p]][l*8 +: 8] = wdata_i[p][l*8 +: 8];
                for (int p = 0; p < NP; p++) begin
                    neww[p] = mem_m[addr_i[p]];
                    rv[p]   = req_i[p] && !we_i[p];
                end
                if (init_i) begin
                    m_clear = 1'b1; m_ptr = 0;
                end
            end
            exp_v1 = rv;
            for (int p = 0; p < NP; p++) if (rv[p]) exp_d1[p] = neww[p];
            exp_v2 = hv;
            for (int p = 0; p < NP; p++) if (hv[p]) exp_d2[p] = hd[p];
            hv = rv; hd = oldw;
            exp_coll = cl;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b1; init_i = 1'b0; idle(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy got %b%b want 11", busy_a, busy_b); end
        total++; if ({rvalid_a, rvalid_b, coll_a, coll_b} !== 8'h00) begin bad++; $display("FAIL reset_flags got %h want 00", {rvalid_a, rvalid_b, coll_a, coll_b}); end
        total++; if (rdata_a !== '0 || rdata_b !== '0) begin bad++; $display("FAIL reset_rdata got %h %h want 0", rdata_a, rdata_b); end
        rst_n = 1'b1;
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin tick(); n++; end
        total++; if (n != DEP) begin bad++; $display("FAIL sweep_len got %0d want %0d", n, DEP); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL sweep_busy_b got %b want 0", busy_b); end
    endtask

    task automatic test_read_all();
        for (int a = 0; a < DEP; a++) begin
            idle();
            set_port(0, 1'b1, 1'b0, 4'h0, AW'(a), '0);
            set_port(1, 1'b1, 1'b0, 4'h0, AW'(DEP - 1 - a), '0);
            tick();
            total++; if (rvalid_a !== 2'b11 || rdata_a[0] !== INIT || rdata_a[1] !== INIT) begin
                bad++; $display("FAIL read_all_a addr %0d got %b %h want 11 %h", a, rvalid_a, rdata_a, INIT); end
            if (a > 0) begin
                total++; if (rvalid_b !== 2'b11 || rdata_b[0] !== INIT || rdata_b[1] !== INIT) begin
                    bad++; $display("FAIL read_all_b addr %0d got %b %h want 11 %h", a, rvalid_b, rdata_b, INIT); end
            end
        end
        idle(); tick();
        total++; if (rvalid_a !== 2'b00 || rvalid_b !== 2'b11) begin
            bad++; $display("FAIL read_all_tail got %b %b want 00 11", rvalid_a, rvalid_b); end
    endtask

    task automatic test_out_of_range();
        idle();
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd13, '0);
        set_port(1, 1'b1, 1'b1, 4'hF, 4'd14, 32'h12345678);
        tick();
        total++; if (rvalid_c !== 2'b01 || rdata_c[0] !== 32'h0 || busy_c !== 1'b0) begin
            bad++; $display("FAIL oor_read got v=%b d=%h busy=%b want 01 0 0", rvalid_c, rdata_c[0], busy_c); end
        idle();
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd14, '0);
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd2, '0);
        tick();
        total++; if (rvalid_c !== 2'b11 || rdata_c[0] !== 32'h0 || rdata_c[1] !== INIT || coll_c !== 2'b00) begin
            bad++; $display("FAIL oor_write_dropped got v=%b d=%h c=%b want 11 0/%h 00", rvalid_c, rdata_c, coll_c, INIT); end
        total++; if (rdata_a[0] !== 32'h12345678) begin
            bad++; $display("FAIL inrange_14 got %h want 12345678", rdata_a[0]); end
    endtask

    task automatic test_byte_lane();
        idle(); set_port(0, 1'b1, 1'b1, 4'b1111, 4'd3, 32'h11223344); tick();
        idle(); set_port(1, 1'b1, 1'b1, 4'b0010, 4'd3, 32'hFFFFFFFF); tick();
        idle(); set_port(0, 1'b1, 1'b0, 4'h0, 4'd3, '0); tick();
        total++; if (rvalid_a[0] !== 1'b1 || rdata_a[0] !== 32'h1122FF44) begin
            bad++; $display("FAIL byte_lane_a got %b %h want 1 1122ff44", rvalid_a[0], rdata_a[0]); end
        idle(); tick();
        total++; if (rvalid_b[0] !== 1'b1 || rdata_b[0] !== 32'h1122FF44) begin
            bad++; $display("FAIL byte_lane_b got %b %h want 1 1122ff44", rvalid_b[0], rdata_b[0]); end
    endtask

    task automatic test_collision();
        idle();
        set_port(0, 1'b1, 1'b1, 4'b1111, 4'd5, 32'h00000000);
        set_port(1, 1'b1, 1'b1, 4'b1100, 4'd5, 32'hDEADBEEF);
        tick();
        total++; if (coll_a !== 2'b01 || coll_b !== 2'b01) begin
            bad++; $display("FAIL coll_flag got %b %b want 01 01", coll_a, coll_b); end
        idle(); set_port(1, 1'b1, 1'b0, 4'h0, 4'd5, '0); tick();
        total++; if (coll_a !== 2'b00 || rvalid_a !== 2'b10 || rdata_a[1] !== 32'hDEAD0000) begin
            bad++; $display("FAIL coll_merge got c=%b v=%b d=%h want 00 10 dead0000", coll_a, rvalid_a, rdata_a[1]); end
    endtask

    task automatic test_read_during_write();
        idle(); set_port(0, 1'b1, 1'b1, 4'hF, 4'd7, 32'd1); tick();
        idle();
        set_port(0, 1'b1, 1'b1, 4'hF, 4'd7, 32'd2);
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd7, '0);
        tick();
        total++; if (rvalid_a !== 2'b10 || rdata_a[1] !== 32'd2) begin
            bad++; $display("FAIL rdw_write_first got %b %h want 10 2", rvalid_a, rdata_a[1]); end
        idle(); tick();
        total++; if (rvalid_b !== 2'b10 || rdata_b[1] !== 32'd1) begin
            bad++; $display("FAIL rdw_read_first got %b %h want 10 1", rvalid_b, rdata_b[1]); end
    endtask

    task automatic test_en_stall();
        idle(); set_port(0, 1'b1, 1'b0, 4'h0, 4'd3, '0); tick();
        total++; if (rvalid_b !== 2'b00 || rvalid_a !== 2'b01) begin
            bad++; $display("FAIL stall_first_edge got %b %b want 00 01", rvalid_b, rvalid_a); end
        idle(); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rvalid_b !== 2'b00 || rvalid_a !== 2'b01 || rdata_a[0] !== 32'h1122FF44) begin
                bad++; $display("FAIL stall_hold cyc %0d got %b %b %h want 00 01 1122ff44", i, rvalid_b, rvalid_a, rdata_a[0]); end
        end
        en = 1'b1; tick();
        total++; if (rvalid_b !== 2'b01 || rdata_b[0] !== 32'h1122FF44 || rvalid_a !== 2'b00) begin
            bad++; $display("FAIL stall_release got %b %h %b want 01 1122ff44 00", rvalid_b, rdata_b[0], rvalid_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < NP; p++)
                set_port(p, 1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom_range(0, 3)), $urandom);
            tick();
            total++; if (rvalid_a !== exp_v1 || coll_a !== exp_coll || busy_a !== m_clear) begin
                bad++; $display("FAIL rand_ctl_a cyc %0d got v=%b c=%b b=%b want v=%b c=%b b=%b", i, rvalid_a, coll_a, busy_a, exp_v1, exp_coll, m_clear); end
            total++; if (rvalid_b !== exp_v2 || coll_b !== exp_coll) begin
                bad++; $display("FAIL rand_ctl_b cyc %0d got v=%b c=%b want v=%b c=%b", i, rvalid_b, coll_b, exp_v2, exp_coll); end
            for (int p = 0; p < NP; p++) begin
                if (exp_v1[p]) begin
                    total++; if (rdata_a[p] !== exp_d1[p]) begin bad++; $display("FAIL rand_data_a cyc %0d port %0d got %h want %h", i, p, rdata_a[p], exp_d1[p]); end
                end
                if (exp_v2[p]) begin
                    total++; if (rdata_b[p] !== exp_d2[p]) begin bad++; $display("FAIL rand_data_b cyc %0d port %0d got %h want %h", i, p, rdata_b[p], exp_d2[p]); end
                end
            end
        end
        en = 1'b1; idle();
    endtask

    task automatic test_init_reset();
        int n;
        idle();
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd3, '0);
        set_port(1, 1'b1, 1'b1, 4'hF, 4'd9, 32'hCAFEF00D);
        init_i = 1'b1;
        tick();
        init_i = 1'b0; idle();
        total++; if (busy_a !== 1'b1 || rvalid_a !== 2'b01 || rdata_a[0] !== exp_d1[0]) begin
            bad++; $display("FAIL init_take got b=%b v=%b d=%h want 1 01 %h", busy_a, rvalid_a, rdata_a[0], exp_d1[0]); end
        tick();
        total++; if (rvalid_b !== 2'b01 || rdata_b[0] !== exp_d2[0]) begin
            bad++; $display("FAIL init_inflight got v=%b d=%h want 01 %h", rvalid_b, rdata_b[0], exp_d2[0]); end
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        total++; if (busy_a !== 1'b1 || busy_b !== 1'b1 || {rvalid_a, rvalid_b, coll_a, coll_b} !== 8'h00 || rdata_a !== '0 || rdata_b !== '0) begin
            bad++; $display("FAIL midsweep_reset got b=%b%b flags=%h d=%h %h want 11 00 0", busy_a, busy_b, {rvalid_a, rvalid_b, coll_a, coll_b}, rdata_a, rdata_b); end
        repeat (2) tick();
        total++; if (busy_a !== 1'b1 || rdata_a !== '0) begin
            bad++; $display("FAIL reset_held got b=%b d=%h want 1 0", busy_a, rdata_a); end
        rst_n = 1'b1; model_reset();
        n = 0;
        while (busy_a === 1'b1 && n < 40) begin
            init_i = (n < 4);
            tick();
            n++;
        end
        init_i = 1'b0;
        total++; if (n != DEP) begin bad++; $display("FAIL resweep_len got %0d want %0d", n, DEP); end
        set_port(0, 1'b1, 1'b0, 4'h0, 4'd3, '0);
        set_port(1, 1'b1, 1'b0, 4'h0, 4'd9, '0);
        tick();
        total++; if (rvalid_a !== 2'b11 || rdata_a[0] !== INIT || rdata_a[1] !== INIT) begin
            bad++; $display("FAIL resweep_data got %b %h want 11 %h", rvalid_a, rdata_a, INIT); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_out_of_range();
        test_byte_lane();
        test_collision();
        test_read_during_write();
        test_en_stall();
        test_random();
        test_init_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
